code_lock_ctrl: RTL
===================

# code_lock_ctrl

Parametrised keypad code-lock controller, successor to the single-code decider. It consumes the 4-bit keypad code stream (digits 0–9, `*`=4'b1010, `#`=4'b1011), compares a CODE_LEN-digit entry against a stored code, and drives OPEN, LOCK and SAVE_LIGHT. The stored code can be changed at run time through a verified two-entry save sequence. A failed-attempt counter with a timed lockout protects against guessing.

## Interface
- CODE_LEN, 4: digits per code, range 2–8.
- DEFAULT_CODE, 32'h0000_1234: reset code, BCD nibbles; the low CODE_LEN nibbles are used, with the first-entered digit in the most significant used nibble.
- OPEN_CYCLES, 8: number of cycles OPEN is held after a match.
- MAX_TRIES, 3: consecutive mismatches that trigger lockout, minimum 1.
- LOCKOUT_CYCLES, 16: lockout duration in cycles.

- clk  in  1  system clock, rising edge.
- reset_1  in  1  asynchronous, active-high reset.
- Code_1  in  4  key code; sampled only when Valid_1=1.
- Valid_1  in  1  single-cycle key strobe, one per key press.
- OPEN  out  1  lock released.
- LOCK  out  1  error/locked indicator.
- SAVE_LIGHT  out  1  save (code-change) mode active.
- ERR_CNT  out  $clog2(MAX_TRIES+1)  consecutive-mismatch count.

## Operation
- Key classes:
  - digit: 0–9.
  - `*`, `#`: terminators.
  - codes 4'b1100–4'b1111: ignored in every state.
- Entry buffer:
  - Shift register of CODE_LEN nibbles; each accepted digit shifts in at the LSB.
  - Digit counter saturates at CODE_LEN+1. Reaching CODE_LEN+1 sets an overflow condition.
  - Buffer and counter clear on every terminator and on every state change.
- Match condition: digit counter equals exactly CODE_LEN, buffer equals the stored code, and there is no overflow.
- States: IDLE, OPENED, SAVE_NEW, SAVE_CFM, LOCKOUT.
- IDLE, on a terminator:
  - `#` with match → OPENED. ERR_CNT clears.
  - `*` with match → SAVE_NEW. ERR_CNT clears.
  - any terminator without match → LOCK pulses for 1 cycle and ERR_CNT increments. If the new ERR_CNT equals MAX_TRIES → LOCKOUT. Otherwise stay in IDLE.
- OPENED:
  - OPEN=1; the open timer runs.
  - Timer reaches OPEN_CYCLES → IDLE.
  - `#` → IDLE immediately (manual relock).
  - All other keys are ignored.
- SAVE_NEW:
  - SAVE_LIGHT=1. Digits collect into the buffer.
  - `#` with exactly CODE_LEN digits → copy buffer into the candidate register, go to SAVE_CFM.
  - `#` with a wrong digit count → abort.
  - `*` → abort.
- SAVE_CFM:
  - SAVE_LIGHT=1. Digits collect into the buffer.
  - `#` with buffer equal to candidate and exactly CODE_LEN digits → stored code ← candidate, go to IDLE.
  - Otherwise abort.
- Abort: LOCK pulses for 1 cycle; stored code unchanged; ERR_CNT unchanged; go to IDLE.
- LOCKOUT:
  - LOCK=1 and all keys are ignored.
  - After LOCKOUT_CYCLES cycles → IDLE, ERR_CNT cleared.
- Reset (asynchronous, at any point including mid-entry or mid-save):
  - state=IDLE, OPEN=0, LOCK=0, SAVE_LIGHT=0, ERR_CNT=0.
  - Buffer, counter, candidate and timers cleared.
  - Stored code ← DEFAULT_CODE.

## Timing
- All outputs are registered. The response to a key sampled at edge k is visible after edge k; there is no combinational path from input to output.
- OPEN is high for exactly OPEN_CYCLES cycles, starting after the edge that samples the matching `#`.
- LOCKOUT holds LOCK high for exactly LOCKOUT_CYCLES cycles. The entering mismatch pulse merges into this interval.
- An error LOCK pulse is exactly 1 cycle wide.
- If Valid_1 arrives on the same edge as OPEN or LOCKOUT timer expiry, expiry wins and the key is discarded.
- Back-to-back Valid_1 on consecutive cycles is legal; every strobe is processed.
- Timers are $clog2(max(OPEN_CYCLES, LOCKOUT_CYCLES)+1) bits wide and count from 0 to N-1. They never wrap.

## Configuration
- CODE_LOCK_LOCKOUT_EN defined:
  - ERR_CNT counts mismatches; the LOCKOUT state and its timer are present as described above.
- Not defined:
  - LOCKOUT state, lockout timer and counter logic are removed; ERR_CNT is tied to 0.
  - A mismatch only produces the 1-cycle LOCK pulse and the FSM stays in IDLE.
  - LOCKOUT_CYCLES and MAX_TRIES are unused.

## Test plan
- Reset, then keys 1,2,3,4,`#` → OPEN high for 8 cycles starting after the `#` edge; LOCK=0 and ERR_CNT=0 throughout.
- Keys 1,2,3,`#` (too few digits), then 1,2,3,4,5,`#` (too many) → two 1-cycle LOCK pulses; ERR_CNT reads 1, then 2; OPEN stays 0.
- Three sequences of 9,9,9,9,`#` (macro defined) → LOCK held 16 cycles; a correct 1,2,3,4,`#` entered during lockout is ignored; the same entry after lockout opens; ERR_CNT=0 after lockout ends.
- Keys 1,2,3,4,`*`, then 5,6,7,8,`#`, then 5,6,7,8,`#` → SAVE_LIGHT high through both entries; afterwards 5,6,7,8,`#` opens and 1,2,3,4,`#` gives a LOCK pulse.
- Save sequence with confirm 5,6,7,9,`#` → 1-cycle LOCK pulse, ERR_CNT unchanged, code stays 1234. Separately: assert reset_1 mid-save, then 1,2,3,4,`#` → OPEN.
- In OPENED: press `#` on cycle 3 → OPEN falls immediately. Press key 4'b1110 in IDLE → no effect.

Source files
------------

// File: rtl/code_lock_ctrl.sv
// Keypad code-lock controller: code entry, verified run-time code change, timed relock.
// Define CODE_LOCK_LOCKOUT_EN to enable the failed-attempt counter and the LOCKOUT state.
module code_lock_ctrl #(
    parameter int unsigned CODE_LEN       = 4,
    parameter logic [31:0] DEFAULT_CODE   = 32'h0000_1234,
    parameter int unsigned OPEN_CYCLES    = 8,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             reset_1,
    input  logic [3:0]                       Code_1,
    input  logic                             Valid_1,
    output logic                             OPEN,
    output logic                             LOCK,
    output logic                             SAVE_LIGHT,
    output logic [$clog2(MAX_TRIES+1)-1:0]   ERR_CNT
);
    localparam int unsigned BUF_W   = 4 * CODE_LEN;
    localparam int unsigned CNT_W   = $clog2(CODE_LEN + 2);
    localparam int unsigned TMR_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPENED,
        S_SAVE_NEW,
        S_SAVE_CFM,
        S_LOCKOUT
    } state_t;

    state_t           state_q, state_d;
    logic [BUF_W-1:0] entry_q, entry_d;
    logic [BUF_W-1:0] stored_q, stored_d;
    logic [BUF_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             open_q, open_d;
    logic             lock_q, lock_d;
    logic             save_q, save_d;

    logic is_digit, is_star, is_hash, is_term, len_ok, match, err_pulse, collecting;

`ifdef CODE_LOCK_LOCKOUT_EN
    localparam int unsigned ERR_W = $clog2(MAX_TRIES + 1);
    logic [ERR_W-1:0] err_q, err_d;
`endif

    assign is_digit = Valid_1 && (Code_1 <= 4'd9);
    assign is_star  = Valid_1 && (Code_1 == 4'hA);
    assign is_hash  = Valid_1 && (Code_1 == 4'hB);
    assign is_term  = is_star || is_hash;
    // An overflowed entry sits at CODE_LEN+1, so an exact count excludes it.
    assign len_ok   = (cnt_q == CNT_W'(CODE_LEN));
    assign match    = len_ok && (entry_q == stored_q);
    assign collecting = (state_q == S_IDLE) || (state_q == S_SAVE_NEW) || (state_q == S_SAVE_CFM);

    always_ff @(posedge clk or posedge reset_1) begin
        if (reset_1) begin
            state_q  <= S_IDLE;
            entry_q  <= '0;
            stored_q <= DEFAULT_CODE[BUF_W-1:0];
            cand_q   <= '0;
            cnt_q    <= '0;
            tmr_q    <= '0;
            open_q   <= 1'b0;
            lock_q   <= 1'b0;
            save_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            stored_q <= stored_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
            open_q   <= open_d;
            lock_q   <= lock_d;
            save_q   <= save_d;
        end
    end

`ifdef CODE_LOCK_LOCKOUT_EN
    always_ff @(posedge clk or posedge reset_1) begin
        if (reset_1) err_q <= '0;
        else         err_q <= err_d;
    end
`endif

    always_comb begin
        state_d   = state_q;
        entry_d   = entry_q;
        stored_d  = stored_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        tmr_d     = tmr_q;
        err_pulse = 1'b0;
`ifdef CODE_LOCK_LOCKOUT_EN
        err_d     = err_q;
`endif

        if (is_digit && collecting) begin
            entry_d = {entry_q[BUF_W-5:0], Code_1};
            if (cnt_q != CNT_W'(CODE_LEN + 1)) cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (is_term && match) begin
                    state_d = is_hash ? S_OPENED : S_SAVE_NEW;
`ifdef CODE_LOCK_LOCKOUT_EN
                    err_d = '0;
`endif
                end else if (is_term) begin
                    err_pulse = 1'b1;
`ifdef CODE_LOCK_LOCKOUT_EN
                    err_d = err_q + 1'b1;
                    if (err_d == ERR_W'(MAX_TRIES)) state_d = S_LOCKOUT;
`endif
                end
            end
            S_OPENED: begin
                // Expiry and manual relock share the exit; a key on the expiry edge is dropped.
                if (tmr_q == TMR_W'(OPEN_CYCLES - 1) || is_hash) state_d = S_IDLE;
                else                                             tmr_d   = tmr_q + 1'b1;
            end
            S_SAVE_NEW: begin
                if (is_hash && len_ok) begin
                    cand_d  = entry_q;
                    state_d = S_SAVE_CFM;
                end else if (is_term) begin
                    err_pulse = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_SAVE_CFM: begin
                if (is_hash && len_ok && (entry_q == cand_q)) begin
                    stored_d = cand_q;
                    state_d  = S_IDLE;
                end else if (is_term) begin
                    err_pulse = 1'b1;
                    state_d   = S_IDLE;
                end
            end
`ifdef CODE_LOCK_LOCKOUT_EN
            S_LOCKOUT: begin
                if (tmr_q == TMR_W'(LOCKOUT_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    err_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (is_term || (state_d != state_q)) begin
            entry_d = '0;
            cnt_d   = '0;
        end
        if (state_d != state_q) tmr_d = '0;
    end

    // Outputs are registered copies of where the FSM is heading.
    assign open_d = (state_d == S_OPENED);
    assign save_d = (state_d == S_SAVE_NEW) || (state_d == S_SAVE_CFM);
    assign lock_d = err_pulse || (state_d == S_LOCKOUT);

    assign OPEN       = open_q;
    assign LOCK       = lock_q;
    assign SAVE_LIGHT = save_q;
`ifdef CODE_LOCK_LOCKOUT_EN
    assign ERR_CNT    = err_q;
`else
    assign ERR_CNT    = '0;
`endif

endmodule
